// File: rtl/prach_hb2_sched_pkg.sv
// Shared PRACH constants for the half-band-by-2 input scheduler.
package prach_hb2_sched_pkg;
  localparam int NUM_CHANNEL = 32;
  localparam int DATA_WIDTH  = 16;
  localparam int CHN_WIDTH   = 8;
endpackage

// File: rtl/prach_hb2_sched.sv
// Pairs even/odd samples of each TDM channel and issues them together to the
// half-band decimator, with frame-sync tracking and sticky error flags.
module prach_hb2_sched
  import prach_hb2_sched_pkg::*;
#(
  parameter int NumChannel = NUM_CHANNEL,
  parameter int DataWidth  = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DataWidth-1:0]  din_dq,
  input  logic                  din_dv,
  input  logic [CHN_WIDTH-1:0]  din_chn,
  input  logic                  sync_in,
  input  logic [NumChannel-1:0] cfg_chn_en,
  input  logic                  err_clr,
  output logic [DataWidth-1:0]  dout_dp1,
  output logic [DataWidth-1:0]  dout_dp2,
  output logic                  dout_dv,
  output logic [CHN_WIDTH-1:0]  dout_chn,
  output logic                  sync_out,
  output logic                  err_chn,
  output logic                  err_sync
);

  localparam logic [CHN_WIDTH-1:0] NCH = CHN_WIDTH'(NumChannel);

  logic [NumChannel-1:0] phase_q, phase_d;
  logic [DataWidth-1:0]  even_q [NumChannel];
  logic [NumChannel-1:0] sel;
  logic [DataWidth-1:0]  even_rd;
  logic                  in_range, chn_en, cur_phase, store, fire;
  logic                  pend_q, pend_d;
  logic [DataWidth-1:0]  dp1_q, dp2_q;
  logic [CHN_WIDTH-1:0]  chn_q;
  logic                  dv_q, sync_out_q, err_chn_q, err_sync_q;

  // Channel decode and asynchronous read of the stored even sample.
  always_comb begin
    sel     = '0;
    even_rd = '0;
    for (int i = 0; i < NumChannel; i++) begin
      sel[i] = (din_chn == CHN_WIDTH'(i));
      if (sel[i]) begin
        even_rd = even_q[i];
      end else begin
        even_rd = even_rd;
      end
    end
  end

  // A sync_in in the same cycle makes the incoming sample an even one.
  always_comb begin
    in_range  = (din_chn < NCH);
    chn_en    = |(sel & cfg_chn_en);
    cur_phase = !sync_in && (|(sel & phase_q));
    store     = din_dv && chn_en && !cur_phase;
    fire      = din_dv && chn_en && cur_phase;

    phase_d = sync_in ? '0 : phase_q;
    if (din_dv && in_range && !chn_en) begin
      phase_d = phase_d & ~sel;
    end else if (store) begin
      phase_d = phase_d | sel;
    end else if (fire) begin
      phase_d = phase_d & ~sel;
    end else begin
      phase_d = phase_d;
    end

    if (sync_in) begin
      pend_d = 1'b1;
    end else if (fire) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      pend_q     <= 1'b0;
      dv_q       <= 1'b0;
      sync_out_q <= 1'b0;
      err_chn_q  <= 1'b0;
      err_sync_q <= 1'b0;
      dp1_q      <= '0;
      dp2_q      <= '0;
      chn_q      <= '0;
    end else begin
      phase_q    <= phase_d;
      pend_q     <= pend_d;
      dv_q       <= fire;
      sync_out_q <= fire && pend_q;
      err_chn_q  <= (din_dv && !in_range) || (err_chn_q && !err_clr);
      err_sync_q <= (sync_in && pend_q) || (err_sync_q && !err_clr);
      if (fire) begin
        dp1_q <= even_rd;
        dp2_q <= din_dq;
        chn_q <= din_chn;
      end
    end
  end

  // Even-sample storage carries no reset; the phase bits gate its use.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NumChannel; i++) begin
      if (store && sel[i]) begin
        even_q[i] <= din_dq;
      end
    end
  end

  assign dout_dp1 = dp1_q;
  assign dout_dp2 = dp2_q;
  assign dout_dv  = dv_q;
  assign dout_chn = chn_q;
  assign sync_out = sync_out_q;
  assign err_chn  = err_chn_q;
  assign err_sync = err_sync_q;

endmodule

// File: tb/tb_prach_hb2_sched.sv
// Self-checking bench: directed scenarios plus a random TDM stream scored
// against a pair-level model built on an associative array of held samples.
module tb_prach_hb2_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] din_dq = 16'd0;
  logic        din_dv = 1'b0;
  logic [7:0]  din_chn = 8'd0;
  logic        sync_in = 1'b0;
  logic [31:0] cfg_en = 32'hFFFF_FFFF;
  logic        err_clr = 1'b0;
  logic [15:0] dout_dp1, dout_dp2;
  logic        dout_dv, sync_out, err_chn, err_sync;
  logic [7:0]  dout_chn;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] held [int];
  bit          m_pend, m_errc, m_errs;
  logic        e_dv, e_sync;
  logic [7:0]  e_chn;
  logic [15:0] e_dp1, e_dp2;
  int          n_pairs;

  prach_hb2_sched dut (
    .clk(clk), .rst(rst), .din_dq(din_dq), .din_dv(din_dv), .din_chn(din_chn),
    .sync_in(sync_in), .cfg_chn_en(cfg_en), .err_clr(err_clr),
    .dout_dp1(dout_dp1), .dout_dp2(dout_dp2), .dout_dv(dout_dv),
    .dout_chn(dout_chn), .sync_out(sync_out), .err_chn(err_chn), .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; din_dv = 1'b0; sync_in = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    held.delete();
    m_pend = 0; m_errc = 0; m_errs = 0;
    e_dv = 0; e_sync = 0; e_chn = 8'd0; e_dp1 = 16'd0; e_dp2 = 16'd0;
  endtask

  // One clock of stimulus; the model predicts what the DUT shows after the edge.
  task automatic drive(input logic dv, input logic [7:0] chn, input logic [15:0] dq,
                       input logic sync, input logic clr);
    bit set_c;
    bit set_s;
    set_c = 0; set_s = 0;
    din_dv = dv; din_chn = chn; din_dq = dq; sync_in = sync; err_clr = clr;
    if (sync) begin
      held.delete();
      if (m_pend) set_s = 1;
    end
    e_dv = 0; e_sync = 0;
    if (dv) begin
      if (chn >= 8'd32) set_c = 1;
      else if (!cfg_en[chn]) held.delete(int'(chn));
      else if (held.exists(int'(chn))) begin
        e_dv = 1; e_sync = m_pend; m_pend = 0;
        e_dp1 = held[int'(chn)]; e_dp2 = dq; e_chn = chn;
        held.delete(int'(chn));
        n_pairs++;
      end else held[int'(chn)] = dq;
    end
    if (sync) m_pend = 1;
    m_errc = set_c || (m_errc && !clr);
    m_errs = set_s || (m_errs && !clr);
    @(posedge clk); #1;
    din_dv = 1'b0; sync_in = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [44:0] got;
    do_reset();
    got = {dout_dv, sync_out, err_chn, err_sync, dout_chn, dout_dp1, dout_dp2};
    total++;
    if (got !== 45'd0) begin
      bad++; $display("FAIL reset_state: got %h want 0", got);
    end
  endtask

  task automatic test_basic();
    logic [41:0] got;
    do_reset();
    drive(1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
    drive(1'b1, 8'd0, 16'd100, 1'b0, 1'b0);
    total++;
    if (dout_dv !== 1'b0) begin bad++; $display("FAIL basic_even0: dv got %b want 0", dout_dv); end
    drive(1'b1, 8'd1, 16'd300, 1'b0, 1'b0);
    drive(1'b1, 8'd0, 16'd200, 1'b0, 1'b0);
    got = {dout_dv, sync_out, dout_chn, dout_dp1, dout_dp2};
    total++;
    if (got !== {1'b1, 1'b1, 8'd0, 16'd100, 16'd200}) begin
      bad++; $display("FAIL basic_pair0: got %h want %h", got, {1'b1, 1'b1, 8'd0, 16'd100, 16'd200});
    end
    drive(1'b1, 8'd1, 16'd400, 1'b0, 1'b0);
    got = {dout_dv, sync_out, dout_chn, dout_dp1, dout_dp2};
    total++;
    if (got !== {1'b1, 1'b0, 8'd1, 16'd300, 16'd400}) begin
      bad++; $display("FAIL basic_pair1: got %h want %h", got, {1'b1, 1'b0, 8'd1, 16'd300, 16'd400});
    end
    drive(1'b0, 8'd0, 16'd0, 1'b0, 1'b0);
    got = {dout_dv, sync_out, dout_chn, dout_dp1, dout_dp2};
    total++;
    if (got !== {1'b0, 1'b0, 8'd1, 16'd300, 16'd400}) begin
      bad++; $display("FAIL basic_hold: got %h want %h", got, {1'b0, 1'b0, 8'd1, 16'd300, 16'd400});
    end
  endtask

  task automatic test_bad_chn();
    do_reset();
    drive(1'b1, 8'd40, 16'd7, 1'b0, 1'b0);
    total++;
    if ({dout_dv, err_chn} !== 2'b01) begin bad++; $display("FAIL badchn_set: dv,err got %b want 01", {dout_dv, err_chn}); end
    drive(1'b0, 8'd0, 16'd0, 1'b0, 1'b1);
    total++;
    if (err_chn !== 1'b0) begin bad++; $display("FAIL badchn_clr: got %b want 0", err_chn); end
    drive(1'b1, 8'd32, 16'd1, 1'b0, 1'b1);
    total++;
    if (err_chn !== 1'b1) begin bad++; $display("FAIL badchn_32_prio: got %b want 1", err_chn); end
    drive(1'b1, 8'd31, 16'd11, 1'b0, 1'b1);
    drive(1'b1, 8'd31, 16'd12, 1'b0, 1'b0);
    total++;
    if ({dout_dv, dout_chn, dout_dp1, dout_dp2, err_chn} !== {1'b1, 8'd31, 16'd11, 16'd12, 1'b0}) begin
      bad++; $display("FAIL badchn_31_ok: got %h want %h", {dout_dv, dout_chn, dout_dp1, dout_dp2, err_chn},
                      {1'b1, 8'd31, 16'd11, 16'd12, 1'b0});
    end
  endtask

  task automatic test_sync_discard();
    logic [41:0] got;
    do_reset();
    drive(1'b1, 8'd3, 16'd5, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
    drive(1'b1, 8'd3, 16'd6, 1'b0, 1'b0);
    total++;
    if (dout_dv !== 1'b0) begin bad++; $display("FAIL syncdisc_nopair: dv got %b want 0", dout_dv); end
    drive(1'b1, 8'd3, 16'd7, 1'b0, 1'b0);
    got = {dout_dv, sync_out, dout_chn, dout_dp1, dout_dp2};
    total++;
    if (got !== {1'b1, 1'b1, 8'd3, 16'd6, 16'd7}) begin
      bad++; $display("FAIL syncdisc_pair: got %h want %h", got, {1'b1, 1'b1, 8'd3, 16'd6, 16'd7});
    end
    // Sample coinciding with sync_in starts a new pair.
    drive(1'b1, 8'd4, 16'd49, 1'b0, 1'b0);
    drive(1'b1, 8'd4, 16'd50, 1'b1, 1'b0);
    total++;
    if (dout_dv !== 1'b0) begin bad++; $display("FAIL syncsame_nopair: dv got %b want 0", dout_dv); end
    drive(1'b1, 8'd4, 16'd51, 1'b0, 1'b0);
    got = {dout_dv, sync_out, dout_chn, dout_dp1, dout_dp2};
    total++;
    if (got !== {1'b1, 1'b1, 8'd4, 16'd50, 16'd51}) begin
      bad++; $display("FAIL syncsame_pair: got %h want %h", got, {1'b1, 1'b1, 8'd4, 16'd50, 16'd51});
    end
  endtask

  task automatic test_disable();
    do_reset();
    cfg_en[2] = 1'b0;
    drive(1'b1, 8'd2, 16'd8, 1'b0, 1'b0);
    drive(1'b1, 8'd2, 16'd9, 1'b0, 1'b0);
    total++;
    if (dout_dv !== 1'b0) begin bad++; $display("FAIL disable_drop: dv got %b want 0", dout_dv); end
    cfg_en[2] = 1'b1;
    drive(1'b1, 8'd2, 16'd10, 1'b0, 1'b0);
    drive(1'b1, 8'd2, 16'd11, 1'b0, 1'b0);
    total++;
    if ({dout_dv, dout_chn, dout_dp1, dout_dp2} !== {1'b1, 8'd2, 16'd10, 16'd11}) begin
      bad++; $display("FAIL disable_reen: got %h want %h", {dout_dv, dout_chn, dout_dp1, dout_dp2},
                      {1'b1, 8'd2, 16'd10, 16'd11});
    end
    drive(1'b1, 8'd2, 16'd12, 1'b0, 1'b0);
    cfg_en[2] = 1'b0;
    drive(1'b1, 8'd2, 16'd99, 1'b0, 1'b0);
    cfg_en[2] = 1'b1;
    drive(1'b1, 8'd2, 16'd13, 1'b0, 1'b0);
    total++;
    if (dout_dv !== 1'b0) begin bad++; $display("FAIL disable_phase0: dv got %b want 0", dout_dv); end
    drive(1'b1, 8'd2, 16'd14, 1'b0, 1'b0);
    total++;
    if ({dout_dv, dout_dp1, dout_dp2} !== {1'b1, 16'd13, 16'd14}) begin
      bad++; $display("FAIL disable_repair: got %h want %h", {dout_dv, dout_dp1, dout_dp2}, {1'b1, 16'd13, 16'd14});
    end
  endtask

  task automatic test_double_sync();
    do_reset();
    drive(1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
    total++;
    if (err_sync !== 1'b0) begin bad++; $display("FAIL dsync_first: got %b want 0", err_sync); end
    drive(1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
    total++;
    if (err_sync !== 1'b1) begin bad++; $display("FAIL dsync_err: got %b want 1", err_sync); end
    drive(1'b1, 8'd5, 16'd1, 1'b0, 1'b0);
    drive(1'b1, 8'd5, 16'd2, 1'b0, 1'b0);
    total++;
    if ({dout_dv, sync_out, err_sync} !== 3'b111) begin
      bad++; $display("FAIL dsync_pair: dv,sync,err got %b want 111", {dout_dv, sync_out, err_sync});
    end
    drive(1'b0, 8'd0, 16'd0, 1'b0, 1'b1);
    total++;
    if ({sync_out, err_sync} !== 2'b00) begin bad++; $display("FAIL dsync_clr: got %b want 00", {sync_out, err_sync}); end
  endtask

  task automatic test_reset_midpair();
    do_reset();
    drive(1'b1, 8'd6, 16'd70, 1'b0, 1'b0);
    do_reset();
    drive(1'b1, 8'd6, 16'd71, 1'b0, 1'b0);
    total++;
    if (dout_dv !== 1'b0) begin bad++; $display("FAIL rstmid_even: dv got %b want 0", dout_dv); end
    drive(1'b1, 8'd6, 16'd72, 1'b0, 1'b0);
    total++;
    if ({dout_dv, dout_dp1, dout_dp2} !== {1'b1, 16'd71, 16'd72}) begin
      bad++; $display("FAIL rstmid_pair: got %h want %h", {dout_dv, dout_dp1, dout_dp2}, {1'b1, 16'd71, 16'd72});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 8'd7, 16'(1000 + k), 1'b0, 1'b0);
      total++;
      if (k % 2 == 1) begin
        if ({dout_dv, dout_chn, dout_dp1, dout_dp2} !== {1'b1, 8'd7, 16'(999 + k), 16'(1000 + k)}) begin
          bad++; $display("FAIL b2b_pair%0d: got %h want %h", k, {dout_dv, dout_chn, dout_dp1, dout_dp2},
                          {1'b1, 8'd7, 16'(999 + k), 16'(1000 + k)});
        end
      end else if (dout_dv !== 1'b0) begin
        bad++; $display("FAIL b2b_even%0d: dv got %b want 0", k, dout_dv);
      end
    end
  endtask

  task automatic test_random();
    logic [44:0] got, exp;
    logic [7:0]  chn;
    do_reset();
    cfg_en = 32'hFFFF_FFFF;
    n_pairs = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) cfg_en = cfg_en ^ (32'h1 << $urandom_range(0, 31));
      if (n % 500 == 0) cfg_en = 32'hFFFF_FFFF;
      chn = ($urandom_range(0, 49) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
      drive($urandom_range(0, 99) < 85, chn, 16'($urandom), $urandom_range(0, 99) == 0,
            $urandom_range(0, 29) == 0);
      got = {dout_dv, sync_out, err_chn, err_sync, dout_chn, dout_dp1, dout_dp2};
      exp = {e_dv, e_sync, m_errc, m_errs, e_chn, e_dp1, e_dp2};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL random_cyc%0d: got %h want %h", n, got, exp);
      end
    end
    total++;
    if (n_pairs < 200) begin bad++; $display("FAIL random_pairs: got %0d want >=200", n_pairs); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_chn();
    test_sync_discard();
    test_disable();
    test_double_sync();
    test_reset_midpair();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prach_hb2_sched.md
PRACH_HB2_SCHED -- requirements
Module: prach_hb2_sched

Interface
REQ-001 SHALL have parameter NumChannel, default 32, number of TDM channels; legal range 1..32.
REQ-002 SHALL have parameter DataWidth, default 16, sample width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port din_dq  input  DataWidth  input sample, one channel per valid cycle.
REQ-006 SHALL have port din_dv  input  1  input sample valid.
REQ-007 SHALL have port din_chn  input  8  channel index of din_dq.
REQ-008 SHALL have port sync_in  input  1  frame start, single-cycle pulse.
REQ-009 SHALL have port cfg_chn_en  input  NumChannel  per-channel enable; 0 means that channel's samples are dropped.
REQ-010 SHALL have port err_clr  input  1  clears the sticky error flags.
REQ-011 SHALL have port dout_dp1  output  DataWidth  even-phase (older) sample of the pair.
REQ-012 SHALL have port dout_dp2  output  DataWidth  odd-phase (newer) sample of the pair.
REQ-013 SHALL have port dout_dv  output  1  pair valid; feeds the half-band decimator's input valid.
REQ-014 SHALL have port dout_chn  output  8  channel of the pair.
REQ-015 SHALL have port sync_out  output  1  marks the first pair issued after sync_in.
REQ-016 SHALL have port err_chn  output  1  sticky flag: a sample arrived with din_chn >= NumChannel.
REQ-017 SHALL have port err_sync  output  1  sticky flag: sync_in arrived while sync_out was still pending.

Function
REQ-018 SHALL keep a per-channel phase bit and a per-channel DataWidth-bit even-sample register.
REQ-019 Accepted sample (din_dv=1, din_chn < NumChannel, cfg_chn_en[din_chn]=1), phase 0: SHALL store din_dq, set phase to 1 and produce no output.
REQ-020 Accepted sample, phase 1: SHALL output dout_dp1 = stored sample, dout_dp2 = din_dq, dout_chn = din_chn, dout_dv = 1, and clear the phase.
REQ-021 Latency SHALL be exactly 1 cycle from the odd input to dout_dv; all outputs SHALL be registered.
REQ-022 When dout_dv=0, dout_dp1/dout_dp2/dout_chn SHALL hold their previous values.
REQ-023 din_chn >= NumChannel with din_dv=1: SHALL drop the sample, leave all phases unchanged and set err_chn.
REQ-024 Disabled channel: SHALL drop the sample and force that channel's phase to 0.
REQ-025 sync_in=1: SHALL clear every phase bit and set a sync-pending flag.
REQ-026 If din_dv=1 arrives in the same cycle as sync_in, that sample SHALL be handled as phase 0 after the clear: it is stored and its channel's phase becomes 1.
REQ-027 sync_out SHALL be 1 together with the first dout_dv=1 after the pending flag is set; that same cycle SHALL clear the pending flag.
REQ-028 sync_in while pending is already set: SHALL set err_sync; the pending flag stays set.
REQ-029 err_clr=1 SHALL clear err_chn and err_sync in the next cycle; if an error event occurs in the same cycle, the set SHALL take priority.
REQ-030 Channel arrival order SHALL be unconstrained; the same channel on consecutive cycles SHALL work without hazard.

Reset
REQ-031 While rst=1, the following SHALL read 0 one cycle later: every phase bit, the pending flag, dout_dv, sync_out, err_chn, err_sync, dout_dp1, dout_dp2 and dout_chn.
REQ-032 The stored-sample array SHALL need no reset.
REQ-033 Reset asserted mid-pair SHALL discard the half-pair; the first sample after release SHALL be treated as phase 0.

Structure
REQ-034 NumChannel, DataWidth and the channel-index width SHALL be defined in the shared prach package, next to the other hb2 constants.
REQ-035 There SHALL be no sub-module; the phase and sample storage SHALL be flops or distributed RAM with an asynchronous read.

Verification
REQ-036 Reset, then sync_in; ch0 gets 100 then 200, ch1 gets 300 then 400 (TDM interleaved) -> pairs (100,200,ch0) with sync_out=1, then (300,400,ch1) with sync_out=0.
REQ-037 din_chn=40 with din_dv=1 -> no dout_dv, err_chn=1; err_clr -> err_chn=0 next cycle.
REQ-038 ch3 gets 5, then sync_in, then ch3 gets 6 and 7 -> one pair (6,7,ch3); 5 is discarded.
REQ-039 cfg_chn_en[2]=0, ch2 gets 8 and 9 -> no output; re-enable, then 10 and 11 -> pair (10,11,ch2).
REQ-040 Two sync_in pulses with no output between them -> err_sync=1; the next pair carries sync_out=1.
REQ-041 Random TDM stream over 32 channels, compared against a reference-model scoreboard -> exact pair and sync match, with 1-cycle latency.
